// File: rtl/core_hazard_pkg.sv
// Shared hazard constants for the pipelined core.
// Register file geometry and producer latency classes.
package core_hazard_pkg;

    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam int LAT_W  = 3;

    localparam logic [LAT_W-1:0] LAT_ALU  = 3'd0;
    localparam logic [LAT_W-1:0] LAT_LOAD = 3'd1;
    localparam logic [LAT_W-1:0] LAT_MUL  = 3'd2;
    localparam logic [LAT_W-1:0] LAT_DIV  = 3'd7;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: cycles left until the pending
// write to this register can be forwarded.
module hazard_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [LAT_W-1:0] set_lat,
    output logic [LAT_W-1:0] busy
);

    logic [LAT_W-1:0] busy_q;
    logic [LAT_W-1:0] busy_d;

    // New issue overrides the running countdown
    always_comb begin
        busy_d = busy_q;
        if (set) begin
            busy_d = set_lat;
        end else if (busy_q != '0) begin
            busy_d = busy_q - 1'b1;
        end
    end

    // Slot register, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard beside ID: RAW/WAW
// stalls, branch flush and a saturating stall counter.
module hazard_scoreboard #(
    parameter int NREG   = core_hazard_pkg::NREG,
    parameter int REG_AW = core_hazard_pkg::REG_AW,
    parameter int LAT_W  = core_hazard_pkg::LAT_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              branch_taken,
    output logic              stall,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              flush_if_id,
    output logic              id_ex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    import core_hazard_pkg::*;

    logic [NREG-1:0][LAT_W-1:0] busy;
    logic                       raw_hz;
    logic                       waw_hz;
    logic                       stall_int;
    logic                       issue;
    logic [CNT_W-1:0]           stall_count_q;
    logic [CNT_W-1:0]           stall_count_d;

    assign busy[0] = '0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_entry
            logic set;
            assign set = issue & id_regwrite
                       & (id_rd == REG_AW'(r));
            hazard_sb_entry #(
                .LAT_W(LAT_W)
            ) u_entry (
                .clk    (clk),
                .rst    (rst),
                .set    (set),
                .set_lat(id_lat),
                .busy   (busy[r])
            );
        end
    endgenerate

    // Hazard detection; a redirect squashes rather than stalls
    always_comb begin
        raw_hz = id_valid
               & ((id_use_rs1 & (busy[id_rs1] != '0))
               |  (id_use_rs2 & (busy[id_rs2] != '0)));
        waw_hz = id_valid & id_regwrite
               & (id_rd != '0)
               & (busy[id_rd] > id_lat);
        stall_int = (raw_hz | waw_hz) & ~branch_taken;
        issue     = id_valid & ~stall_int & ~branch_taken;
    end

    // Stall counter sticks at all-ones instead of wrapping
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_int && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Performance counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall          = stall_int;
    assign pc_write_en    = ~stall_int;
    assign if_id_write_en = ~stall_int;
    assign flush_if_id    = branch_taken;
    assign id_ex_bubble   = stall_int | branch_taken;
    assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a ready-time
// register model queues expectations, a monitor checks.
module tb_hazard_scoreboard;

    import core_hazard_pkg::*;

    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [4:0]    id_rd;
    logic          id_regwrite;
    logic [2:0]    id_lat;
    logic          branch_taken;
    logic          stall;
    logic          pc_write_en;
    logic          if_id_write_en;
    logic          flush_if_id;
    logic          id_ex_bubble;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .CNT_W(CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_rd         (id_rd),
        .id_regwrite   (id_regwrite),
        .id_lat        (id_lat),
        .branch_taken  (branch_taken),
        .stall         (stall),
        .pc_write_en   (pc_write_en),
        .if_id_write_en(if_id_write_en),
        .flush_if_id   (flush_if_id),
        .id_ex_bubble  (id_ex_bubble),
        .stall_count   (stall_count)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic [2:0] lat;
        logic       br;
    } ins_t;

    typedef struct packed {
        logic          st;
        logic          pcw;
        logic          ifw;
        logic          fl;
        logic          bub;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    longint ready[32];
    longint cyc_n = 0;
    int     mcnt = 0;

    function automatic ins_t mk(bit v, int rs1, int rs2, bit u1,
                                bit u2, int rd, bit rw, int lat,
                                bit br);
        ins_t i;
        i.v   = v;
        i.rs1 = 5'(rs1);
        i.rs2 = 5'(rs2);
        i.u1  = u1;
        i.u2  = u2;
        i.rd  = 5'(rd);
        i.rw  = rw;
        i.lat = 3'(lat);
        i.br  = br;
        return i;
    endfunction

    // Cycles still to wait before register r is forwardable
    function automatic int mbusy(logic [4:0] r);
        if (r == 5'd0) return 0;
        if (ready[r] > cyc_n) return int'(ready[r] - cyc_n);
        return 0;
    endfunction

    task automatic chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic cyc(input ins_t i, input logic r,
                       input bit ck, output bit st);
        bit raw;
        bit waw;
        bit s;
        exp_t e;
        rst          = r;
        id_valid     = i.v;
        id_rs1       = i.rs1;
        id_rs2       = i.rs2;
        id_use_rs1   = i.u1;
        id_use_rs2   = i.u2;
        id_rd        = i.rd;
        id_regwrite  = i.rw;
        id_lat       = i.lat;
        branch_taken = i.br;
        raw = i.v && ((i.u1 && mbusy(i.rs1) != 0)
                   || (i.u2 && mbusy(i.rs2) != 0));
        waw = i.v && i.rw && i.rd != 0
           && mbusy(i.rd) > int'(i.lat);
        s = (raw || waw) && !i.br;
        e.st  = s;
        e.pcw = !s;
        e.ifw = !s;
        e.fl  = i.br;
        e.bub = s || i.br;
        e.cnt = CW'(mcnt);
        if (ck) exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 32; k++) ready[k] = 0;
            mcnt = 0;
        end else begin
            if (i.v && !s && !i.br && i.rw && i.rd != 0)
                ready[i.rd] = cyc_n + 1 + longint'(i.lat);
            if (s && mcnt < CMAX) mcnt++;
        end
        cyc_n++;
        #1;
        st = s;
    endtask

    task automatic hold(input ins_t i, output int n);
        bit st;
        n = 0;
        do begin
            cyc(i, 1'b0, 1'b1, st);
            if (st) n++;
        end while (st && n < 32);
        if (st) chk("hold_timeout", 1, 0);
    endtask

    task automatic rst_cyc();
        bit st;
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, st);
    endtask

    task automatic op(input ins_t i);
        bit st;
        cyc(i, 1'b0, 1'b1, st);
    endtask

    // Monitor: compare DUT outputs to the oldest expectation
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {stall, pc_write_en, if_id_write_en,
                     flush_if_id, id_ex_bubble, stall_count};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got st=%b pcw=%b ifw=%b fl=%b bub=%b cnt=%0d expected st=%b pcw=%b ifw=%b fl=%b bub=%b cnt=%0d",
                             $time, g.st, g.pcw, g.ifw, g.fl,
                             g.bub, g.cnt, e.st, e.pcw, e.ifw,
                             e.fl, e.bub, e.cnt);
                end
            end
        end
    end

    initial begin
        int   n;
        bit   st;
        ins_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 32; k++) ready[k] = 0;
        cyc(nop, 1'b1, 1'b0, st);
        cyc(nop, 1'b1, 1'b0, st);

        op(nop);
        chk("reset_count", int'(stall_count), 0);

        rst_cyc();
        op(mk(1, 0, 0, 0, 0, 5, 1, int'(LAT_LOAD), 0));
        hold(mk(1, 5, 0, 1, 0, 6, 1, 0, 0), n);
        chk("loaduse_stalls", n, 1);
        chk("loaduse_count", int'(stall_count), 1);

        rst_cyc();
        op(mk(1, 0, 0, 0, 0, 7, 1, 4, 0));
        hold(mk(1, 0, 7, 0, 1, 8, 1, 0, 0), n);
        chk("mul4_stalls", n, 4);
        chk("mul4_count", int'(stall_count), 4);
        op(mk(1, 0, 0, 0, 0, 4, 1, int'(LAT_MUL), 0));
        hold(mk(1, 4, 4, 1, 1, 0, 0, 0, 0), n);
        chk("mul2_stalls", n, 2);

        rst_cyc();
        op(mk(1, 0, 0, 0, 0, 0, 1, 4, 0));
        hold(mk(1, 0, 0, 1, 1, 1, 1, 0, 0), n);
        chk("x0_stalls", n, 0);
        op(mk(1, 0, 0, 0, 0, 3, 1, int'(LAT_ALU), 0));
        hold(mk(1, 3, 3, 1, 1, 2, 1, 0, 0), n);
        chk("alu_stalls", n, 0);
        chk("x0_alu_count", int'(stall_count), 0);

        rst_cyc();
        op(mk(1, 0, 0, 0, 0, 9, 1, 4, 0));
        hold(mk(1, 0, 0, 0, 0, 9, 1, 0, 0), n);
        chk("waw_lat0_stalls", n, 4);
        rst_cyc();
        op(mk(1, 0, 0, 0, 0, 9, 1, 4, 0));
        hold(mk(1, 0, 0, 0, 0, 9, 1, 3, 0), n);
        chk("waw_lat3_stalls", n, 1);

        rst_cyc();
        op(mk(1, 0, 0, 0, 0, 5, 1, int'(LAT_LOAD), 0));
        op(mk(1, 5, 0, 1, 0, 5, 1, 4, 1));
        hold(mk(1, 5, 0, 1, 0, 6, 1, 0, 0), n);
        chk("flush_then_stalls", n, 0);
        chk("flush_count", int'(stall_count), 0);

        rst_cyc();
        op(mk(1, 0, 0, 0, 0, 7, 1, 3, 0));
        cyc(mk(1, 7, 0, 1, 0, 0, 0, 0, 0), 1'b1, 1'b1, st);
        chk("midreset_count", int'(stall_count), 0);
        hold(mk(1, 7, 0, 1, 0, 0, 0, 0, 0), n);
        chk("midreset_stalls", n, 0);

        rst_cyc();
        for (int k = 0; k < 6; k++) begin
            op(mk(1, 0, 0, 0, 0, 7, 1, int'(LAT_DIV), 0));
            hold(mk(1, 7, 0, 1, 0, 0, 0, 0, 0), n);
            chk("div_stalls", n, 7);
        end
        chk("sat_count", int'(stall_count), CMAX);
        op(mk(1, 0, 0, 0, 0, 7, 1, int'(LAT_DIV), 0));
        hold(mk(1, 7, 0, 1, 0, 0, 0, 0, 0), n);
        chk("sat_hold", int'(stall_count), CMAX);

        for (int k = 0; k < 1500; k++) begin
            cyc(mk(($urandom % 8) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom % 2, $urandom % 2,
                   $urandom_range(0, 7), $urandom % 2,
                   $urandom_range(0, 7), ($urandom % 10) == 0),
                ($urandom % 40) == 0, 1'b1, st);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
